// File: rtl/result_bcd_converter_pkg.sv
// Shared definitions for the signed-result to BCD conversion path and the display driver.
package result_bcd_converter_pkg;

  localparam int unsigned N_DEF      = 5;
  localparam int unsigned DIGITS_DEF = 2;
  localparam int unsigned BCD_W      = 4 * DIGITS_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/result_bcd_converter_bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (nib_i >= 4'd5) nib_o = nib_i + 4'd3;
  end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential sign + BCD magnitude converter for the adder's N+1-bit two's-complement result.
module result_bcd_converter
  import result_bcd_converter_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [N:0]            result,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned RW   = N + 1;
  localparam int unsigned BW   = 4 * DIGITS;
  localparam int unsigned SH_W = BW + RW;
  localparam int unsigned CW   = $clog2(N + 2);

  state_e          state_q, state_d;
  logic            sign_r_q, sign_r_d;
  logic [RW-1:0]   mag_q, mag_d;
  logic [BW-1:0]   work_q, work_d;
  logic [BW-1:0]   work_adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sign_q, sign_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [SH_W-1:0] shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i(work_q[4*g +: 4]),
      .nib_o(work_adj[4*g +: 4])
    );
  end

  // Next-state and datapath logic
  always_comb begin
    state_d  = state_q;
    sign_r_d = sign_r_q;
    mag_d    = mag_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    bcd_d    = bcd_q;
    done_d   = 1'b0;
    shifted  = {work_adj, mag_q} << 1;

    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        sign_r_d = result[N];
        mag_d    = result[N] ? RW'(-result) : result;
        work_d   = '0;
        cnt_d    = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        work_d = shifted[SH_W-1 -: BW];
        mag_d  = shifted[RW-1:0];
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N)) state_d = DONE;
      end
      DONE: begin
        bcd_d   = work_q;
        sign_d  = sign_r_q & (work_q != '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q  <= IDLE;
      sign_r_q <= 1'b0;
      mag_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      bcd_q    <= '0;
    end else begin
      state_q  <= state_d;
      sign_r_q <= sign_r_d;
      mag_q    <= mag_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sign_q   <= sign_d;
      bcd_q    <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sign = sign_q;
  assign bcd  = bcd_q;

endmodule
